// File: rtl/llr_ram_ctrl.sv
// LLR frame buffer controller: loads one frame of LLRs into an external RAM, then serves decoder reads.
// Latency: writes go out in the handshake cycle; read data returns RD_LAT cycles after an accepted rd_req.
// Backpressure: in_ready drops while a frame is held and until in-flight reads drain. Macro LLR_SAT_EN maps the most-negative LLR to most-negative+1.
module llr_ram_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int LLR_WIDTH  = 8,
    parameter int FRAME_LEN  = 256,
    parameter int RD_LAT     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [LLR_WIDTH-1:0]  in_llr,
    output logic                  in_ready,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    output logic [LLR_WIDTH-1:0]  rd_llr,
    output logic                  frame_ready,
    input  logic                  frame_release,
    output logic                  err,
    output logic [LLR_WIDTH-1:0]  ram_data,
    output logic [ADDR_WIDTH-1:0] ram_wraddress,
    output logic                  ram_wren,
    output logic [ADDR_WIDTH-1:0] ram_rdaddress,
    output logic                  ram_rden,
    input  logic [LLR_WIDTH-1:0]  ram_q
);

    typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(FRAME_LEN - 1);
    localparam logic [ADDR_WIDTH:0]   FRAME_LEN_W = (ADDR_WIDTH + 1)'(FRAME_LEN);

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_cnt;
    logic [RD_LAT-1:0]     vld_pipe;
    logic                  pipe_empty;
    logic                  wr_fire;
    logic                  rd_ok;

    function automatic logic [LLR_WIDTH-1:0] sat_llr(input logic [LLR_WIDTH-1:0] v);
`ifdef LLR_SAT_EN
        // Symmetric range: the lone most-negative code folds onto its neighbour.
        if (v == {1'b1, {(LLR_WIDTH-1){1'b0}}})
            return {1'b1, {(LLR_WIDTH-2){1'b0}}, 1'b1};
        return v;
`else
        return v;
`endif
    endfunction

    assign pipe_empty = ~|vld_pipe;
    assign in_ready   = !rst_n || ((state != FULL) && pipe_empty);
    assign wr_fire    = rst_n && in_valid && in_ready;
    assign rd_ok      = rst_n && rd_req && (state == FULL) && ({1'b0, rd_addr} < FRAME_LEN_W);

    assign ram_wren      = wr_fire;
    assign ram_wraddress = wr_fire ? wr_cnt : '0;
    assign ram_data      = wr_fire ? sat_llr(in_llr) : '0;
    assign ram_rden      = rd_ok;
    assign ram_rdaddress = rd_ok ? rd_addr : '0;

    assign frame_ready = rst_n && (state == FULL);
    assign rd_valid    = rst_n && vld_pipe[RD_LAT-1];
    assign rd_llr      = rd_valid ? ram_q : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            wr_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (rd_req && !rd_ok)
                err <= 1'b1;
            case (state)
                IDLE, LOAD: begin
                    if (wr_fire) begin
                        if (wr_cnt == LAST_ADDR) begin
                            state <= FULL;
                        end else begin
                            state  <= LOAD;
                            wr_cnt <= wr_cnt + ADDR_WIDTH'(1);
                        end
                    end
                end
                FULL: begin
                    if (frame_release) begin
                        state  <= IDLE;
                        wr_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read-valid shift register mirrors the RAM read latency; release does not flush it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--)
                vld_pipe[i] <= vld_pipe[i-1];
            vld_pipe[0] <= rd_ok;
        end
    end

endmodule
